// File: rtl/multi_channel_target_agent_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_target_agent_pkg
// Description : Shared types and constants for the multi-channel target agent.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_channel_target_agent_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } agent_state_e;

    localparam logic [127:0] c_priv_data_default = 128'hABCD_ABCD_DABC_ABCD_ABCD_DABC_DABC_DABC;

    // A single-channel build still needs a one-bit index.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_channel_target_agent_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick starting after the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import multi_channel_target_agent_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IDX_W = ch_idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_CH-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cand;

    // Walk from farthest to nearest so the nearest requester after i_last wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = N_CH; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last) + k) % N_CH);
            if (i_req[w_cand]) begin
                o_gnt         = '0;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                o_valid       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_channel_target_agent.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_target_agent
// Description : Guards one privileged asset shared by N_CH channels; releases
//               it only to the controller-granted channel, locks abusers.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_target_agent
    import multi_channel_target_agent_pkg::*;
#(
    parameter int             D_S       = 128,
    parameter int             N_CH      = 4,
    parameter int             TIMEOUT   = 8,
    parameter int             MAX_VIOL  = 3,
    parameter logic [D_S-1:0] PRIV_DATA = D_S'(c_priv_data_default)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           access_en,
    output logic [N_CH-1:0]           observe_port,
    output logic [N_CH-1:0]           control_port_in,
    input  logic [N_CH-1:0]           control_port_out,
    output logic [D_S-1:0]            priv_data,
    output logic                      priv_valid,
    output logic [ch_idx_w(N_CH)-1:0] priv_ch,
    output logic                      deny_pulse,
    output logic [N_CH-1:0]           locked
);

    localparam int IDX_W = ch_idx_w(N_CH);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int VC_W  = $clog2(MAX_VIOL + 1);

    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);
    localparam logic [VC_W-1:0]  c_viol_max = VC_W'(MAX_VIOL);

    agent_state_e                r_state,       w_state_d;
    logic [IDX_W-1:0]            r_sel,         w_sel_d;
    logic [IDX_W-1:0]            r_last_winner, w_last_winner_d;
    logic [TMR_W-1:0]            r_timer,       w_timer_d;
    logic [N_CH-1:0][VC_W-1:0]   r_viol_cnt,    w_viol_cnt_d;
    logic [N_CH-1:0]             r_locked,      w_locked_d;
    logic [N_CH-1:0]             r_observe;
    logic [N_CH-1:0]             r_ctrl_in,     w_ctrl_in_d;
    logic                        r_priv_valid,  w_priv_valid_d;
    logic                        r_deny,        w_deny_d;

    logic [N_CH-1:0]  w_arb_gnt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_valid;
    logic [VC_W-1:0]  w_viol_nxt;

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (access_en & ~r_locked),
        .i_last  (r_last_winner),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_state_d       = r_state;
        w_sel_d         = r_sel;
        w_last_winner_d = r_last_winner;
        w_timer_d       = r_timer;
        w_viol_cnt_d    = r_viol_cnt;
        w_locked_d      = r_locked;
        w_deny_d        = 1'b0;
        w_viol_nxt      = (r_viol_cnt[r_sel] == c_viol_max) ? r_viol_cnt[r_sel]
                                                             : r_viol_cnt[r_sel] + VC_W'(1);

        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_sel_d   = w_arb_idx;
                    w_timer_d = '0;
                    w_state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_timer_d = r_timer + TMR_W'(1);
                // A dropped request beats a simultaneous grant.
                if (!access_en[r_sel]) begin
                    w_state_d = ST_IDLE;
                end else if (control_port_out[r_sel]) begin
                    w_state_d       = ST_GRANT;
                    w_last_winner_d = r_sel;
                end else if (r_timer == c_tmr_last) begin
                    w_state_d           = ST_IDLE;
                    w_deny_d            = 1'b1;
                    w_viol_cnt_d[r_sel] = w_viol_nxt;
                    if (w_viol_nxt == c_viol_max) begin
                        w_locked_d[r_sel] = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                if (!access_en[r_sel] || !control_port_out[r_sel]) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Outputs are precomputed from the next state so they appear registered.
        w_ctrl_in_d = '0;
        if (w_state_d != ST_IDLE) begin
            w_ctrl_in_d[w_sel_d] = 1'b1;
        end
        w_priv_valid_d = (w_state_d == ST_GRANT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_last_winner <= IDX_W'(N_CH - 1);
            r_timer       <= '0;
            r_viol_cnt    <= '0;
            r_locked      <= '0;
            r_observe     <= '0;
            r_ctrl_in     <= '0;
            r_priv_valid  <= 1'b0;
            r_deny        <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_sel         <= w_sel_d;
            r_last_winner <= w_last_winner_d;
            r_timer       <= w_timer_d;
            r_viol_cnt    <= w_viol_cnt_d;
            r_locked      <= w_locked_d;
            r_observe     <= access_en;
            r_ctrl_in     <= w_ctrl_in_d;
            r_priv_valid  <= w_priv_valid_d;
            r_deny        <= w_deny_d;
        end
    end

    assign observe_port    = r_observe;
    assign control_port_in = r_ctrl_in;
    assign priv_valid      = r_priv_valid;
    assign priv_data       = r_priv_valid ? PRIV_DATA : '0;
    assign priv_ch         = r_sel;
    assign deny_pulse      = r_deny;
    assign locked          = r_locked;

endmodule
`default_nettype wire
